// File: rtl/uart_digit_rotator_pkg.sv
// Shared definitions for the UART-controlled rotating digit display: command bytes,
// blank code default and the decoded command type.
package uart_digit_rotator_pkg;

  localparam logic [7:0] CMD_PLAY_U  = 8'h47;
  localparam logic [7:0] CMD_PLAY_L  = 8'h67;
  localparam logic [7:0] CMD_PAUSE_U = 8'h50;
  localparam logic [7:0] CMD_PAUSE_L = 8'h70;
  localparam logic [7:0] CMD_DIR_U   = 8'h44;
  localparam logic [7:0] CMD_DIR_L   = 8'h64;
  localparam logic [7:0] CMD_CLR_U   = 8'h43;
  localparam logic [7:0] CMD_CLR_L   = 8'h63;
  localparam logic [7:0] CMD_FASTER  = 8'h2B;
  localparam logic [7:0] CMD_SLOWER  = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int unsigned BLANK_CODE_DEF = 16;

  typedef enum logic [3:0] {
    CmdNop,
    CmdPlay,
    CmdPause,
    CmdDir,
    CmdDigit,
    CmdClear,
    CmdFaster,
    CmdSlower,
    CmdErr
  } cmd_t;

endpackage

// File: rtl/uart_cmd_decode.sv
// Combinational UART byte decoder: maps a received byte to a command and, for
// ASCII digits, the 4-bit digit value.
module uart_cmd_decode
  import uart_digit_rotator_pkg::*;
(
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output cmd_t       cmd_o,
  output logic [3:0] digit_o
);

  logic [7:0] offset;
  assign offset  = rx_data_i - ASCII_ZERO;
  assign digit_o = offset[3:0];

  always_comb begin
    cmd_o = CmdNop;
    if (rx_valid_i) begin
      unique case (rx_data_i)
        CMD_PLAY_U, CMD_PLAY_L:   cmd_o = CmdPlay;
        CMD_PAUSE_U, CMD_PAUSE_L: cmd_o = CmdPause;
        CMD_DIR_U, CMD_DIR_L:     cmd_o = CmdDir;
        CMD_CLR_U, CMD_CLR_L:     cmd_o = CmdClear;
        CMD_FASTER:               cmd_o = CmdFaster;
        CMD_SLOWER:               cmd_o = CmdSlower;
        default: begin
          if (rx_data_i >= ASCII_ZERO && rx_data_i <= ASCII_ZERO + 8'd9) cmd_o = CmdDigit;
          else cmd_o = CmdErr;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_digit_rotator.sv
// Rotating digit register file with a programmable step timer, controlled by
// decoded UART command bytes.
module uart_digit_rotator
  import uart_digit_rotator_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned DIGIT_W      = 5,
  parameter int unsigned BASE_TURNS   = 25_000_000,
  parameter int unsigned SPEED_LEVELS = 4,
  parameter int unsigned BLANK_CODE   = BLANK_CODE_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [NUM_DIGITS*DIGIT_W-1:0]   digits,
  output logic                            playing,
  output logic                            reverse,
  output logic [$clog2(SPEED_LEVELS)-1:0] speed,
  output logic                            step,
  output logic                            cmd_err
);

  localparam int unsigned CntW = $clog2(BASE_TURNS);
  localparam int unsigned SpdW = $clog2(SPEED_LEVELS);

  logic [DIGIT_W-1:0] dig_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] dig_d [NUM_DIGITS];
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SpdW-1:0]    spd_q, spd_d;
  logic               play_q, play_d;
  logic               rev_q, rev_d;
  logic               pend_q, pend_d;
  logic               step_q, step_d;
  logic               err_q, err_d;

  cmd_t       cmd;
  logic [3:0] digit_val;
  logic [31:0] period_m1;
  logic        tick;

  uart_cmd_decode u_decode (
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .cmd_o      (cmd),
    .digit_o    (digit_val)
  );

  assign period_m1 = (BASE_TURNS >> spd_q) - 32'd1;
  assign tick      = play_q && (cnt_q == period_m1[CntW-1:0]);

  always_comb begin
    dig_d  = dig_q;
    cnt_d  = cnt_q;
    spd_d  = spd_q;
    play_d = play_q;
    rev_d  = rev_q;
    pend_d = pend_q;
    step_d = 1'b0;
    err_d  = 1'b0;

    if (play_q) cnt_d = tick ? '0 : cnt_q + CntW'(1);
    // Any byte takes priority over rotation; a coincident tick is deferred.
    if (cmd != CmdNop && tick) pend_d = 1'b1;

    unique case (cmd)
      CmdNop: begin
        if (tick || pend_q) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rev_q) dig_d[i] = dig_q[(i + 1) % NUM_DIGITS];
            else       dig_d[i] = dig_q[(i + NUM_DIGITS - 1) % NUM_DIGITS];
          end
          step_d = 1'b1;
          pend_d = 1'b0;
        end
      end
      CmdPlay: play_d = 1'b1;
      CmdPause: begin
        play_d = 1'b0;
        pend_d = 1'b0;
        cnt_d  = cnt_q;
      end
      CmdDir: rev_d = ~rev_q;
      CmdDigit: begin
        dig_d[0] = DIGIT_W'(digit_val);
        for (int i = 1; i < NUM_DIGITS; i++) dig_d[i] = dig_q[i-1];
      end
      CmdClear: begin
        for (int i = 0; i < NUM_DIGITS; i++) dig_d[i] = DIGIT_W'(BLANK_CODE);
      end
      CmdFaster: begin
        if (spd_q != SpdW'(SPEED_LEVELS - 1)) spd_d = spd_q + SpdW'(1);
        cnt_d = '0;
      end
      CmdSlower: begin
        if (spd_q != '0) spd_d = spd_q - SpdW'(1);
        cnt_d = '0;
      end
      CmdErr: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= DIGIT_W'(i % 10);
      cnt_q  <= '0;
      spd_q  <= '0;
      play_q <= 1'b1;
      rev_q  <= 1'b0;
      pend_q <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      cnt_q  <= cnt_d;
      spd_q  <= spd_d;
      play_q <= play_d;
      rev_q  <= rev_d;
      pend_q <= pend_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    digits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) digits[i*DIGIT_W +: DIGIT_W] = dig_q[i];
  end

  assign playing = play_q;
  assign reverse = rev_q;
  assign speed   = spd_q;
  assign step    = step_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_uart_digit_rotator.sv
// Bench for uart_digit_rotator: directed scenarios plus random byte traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_uart_digit_rotator;

  localparam int Base = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [29:0] digits;
  logic        playing, reverse, step, cmd_err;
  logic [1:0]  speed;

  int n_checks = 0;
  int n_bad = 0;

  // Model state: m_q[0] is the rightmost digit.
  int m_q[$];
  bit m_play, m_rev, m_pend, m_step, m_err;
  int m_spd, m_cnt;

  uart_digit_rotator #(
    .NUM_DIGITS   (6),
    .DIGIT_W      (5),
    .BASE_TURNS   (Base),
    .SPEED_LEVELS (4),
    .BLANK_CODE   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .digits   (digits),
    .playing  (playing),
    .reverse  (reverse),
    .speed    (speed),
    .step     (step),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] m_pack();
    logic [29:0] r = '0;
    for (int i = 0; i < 6; i++) r[i*5 +: 5] = 5'(m_q[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < 6; i++) m_q.push_back(i % 10);
    m_play = 1; m_rev = 0; m_pend = 0; m_step = 0; m_err = 0;
    m_spd = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    bit tick;
    int old_cnt;
    tick = m_play && (m_cnt == (Base >> m_spd) - 1);
    old_cnt = m_cnt;
    m_step = 0;
    m_err = 0;
    if (m_play) m_cnt = tick ? 0 : m_cnt + 1;
    if (v) begin
      if (tick) m_pend = 1;
      if (b == 8'h47 || b == 8'h67) m_play = 1;
      else if (b == 8'h50 || b == 8'h70) begin
        m_play = 0; m_pend = 0; m_cnt = old_cnt;
      end
      else if (b == 8'h44 || b == 8'h64) m_rev = !m_rev;
      else if (b >= 8'h30 && b <= 8'h39) begin
        m_q.push_front(int'(b) - 48);
        void'(m_q.pop_back());
      end
      else if (b == 8'h43 || b == 8'h63) begin
        for (int i = 0; i < 6; i++) m_q[i] = 16;
      end
      else if (b == 8'h2B) begin
        if (m_spd < 3) m_spd++;
        m_cnt = 0;
      end
      else if (b == 8'h2D) begin
        if (m_spd > 0) m_spd--;
        m_cnt = 0;
      end
      else m_err = 1;
    end else if (tick || m_pend) begin
      if (m_rev) m_q.push_back(m_q.pop_front());
      else m_q.push_front(m_q.pop_back());
      m_step = 1;
      m_pend = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("digits", 64'(digits), 64'(m_pack()));
    check_eq("playing", 64'(playing), 64'(m_play));
    check_eq("reverse", 64'(reverse), 64'(m_rev));
    check_eq("speed", 64'(speed), 64'(m_spd));
    check_eq("step", 64'(step), 64'(m_step));
    check_eq("cmd_err", 64'(cmd_err), 64'(m_err));
  endtask

  // One clock: inputs applied before the edge, outputs compared 1 ns after it.
  task automatic cyc(input bit v, input logic [7:0] b);
    rx_valid = v;
    rx_data = b;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(v, b);
    #1;
    compare_all();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n, output int steps);
    steps = 0;
    for (int i = 0; i < n; i++) begin
      cyc(0, 8'h00);
      steps += int'(step);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 8'h00);
    rst = 1'b0;
  endtask

  logic [7:0] pool[] = '{8'h47, 8'h67, 8'h44, 8'h64, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
                         8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h2B, 8'h2D, 8'h2B,
                         8'h43, 8'h63, 8'h58, 8'h47};

  initial begin
    int steps;
    int wait_n;
    logic [7:0] b;

    do_reset();
    check_eq("rst_digits", 64'(digits), 64'({5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));

    // Free-running rotation at speed 0.
    idle(16, steps);
    check_eq("first_period_steps", 64'(steps), 64'd1);
    check_eq("rot1_digits", 64'(digits), 64'({5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd5}));
    idle(16, steps);
    check_eq("rot2_digits", 64'(digits), 64'({5'd3, 5'd2, 5'd1, 5'd0, 5'd5, 5'd4}));

    // Pause holds digits and counter; resume finishes the remaining count.
    idle(5, steps);
    cyc(1, 8'h50);
    idle(64, steps);
    check_eq("pause_steps", 64'(steps), 64'd0);
    check_eq("pause_digits", 64'(digits), 64'({5'd3, 5'd2, 5'd1, 5'd0, 5'd5, 5'd4}));
    cyc(1, 8'h67);
    wait_n = 0;
    for (int i = 0; i < 20 && !step; i++) begin
      cyc(0, 8'h00);
      wait_n++;
    end
    check_eq("resume_latency", 64'(wait_n), 64'd11);

    // Direction toggles.
    cyc(1, 8'h44);
    idle(20, steps);
    cyc(1, 8'h64);
    idle(20, steps);

    // Back-to-back inserts while paused.
    do_reset();
    cyc(1, 8'h70);
    cyc(1, 8'h34);
    cyc(1, 8'h35);
    cyc(1, 8'h36);
    check_eq("insert_digits", 64'(digits), 64'({5'd2, 5'd1, 5'd0, 5'd4, 5'd5, 5'd6}));

    // Speed saturation and clear.
    cyc(1, 8'h47);
    for (int i = 0; i < 4; i++) cyc(1, 8'h2B);
    check_eq("speed_max", 64'(speed), 64'd3);
    idle(8, steps);
    check_eq("fast_steps", 64'(steps), 64'd4);
    for (int i = 0; i < 4; i++) cyc(1, 8'h2D);
    check_eq("speed_min", 64'(speed), 64'd0);
    cyc(1, 8'h43);
    check_eq("clear_digits", 64'(digits), 64'({5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16}));

    // Unknown byte, then a digit landing on a tick cycle.
    cyc(1, 8'h58);
    check_eq("err_pulse", 64'(cmd_err), 64'd1);
    do_reset();
    idle(15, steps);
    cyc(1, 8'h37);
    check_eq("tick_insert_digits", 64'(digits), 64'({5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd7}));
    check_eq("tick_insert_nostep", 64'(step), 64'd0);
    cyc(0, 8'h00);
    check_eq("deferred_step", 64'(step), 64'd1);
    check_eq("deferred_digits", 64'(digits), 64'({5'd3, 5'd2, 5'd1, 5'd0, 5'd7, 5'd4}));

    // Reset mid-rotation with a coincident byte.
    cyc(1, 8'h2B);
    idle(7, steps);
    rst = 1'b1;
    cyc(1, 8'h33);
    rst = 1'b0;
    check_eq("midrst_digits", 64'(digits), 64'({5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));
    check_eq("midrst_speed", 64'(speed), 64'd0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        rst = 1'b1;
        cyc(1, 8'($urandom));
        rst = 1'b0;
      end else if (r < 60) begin
        cyc(0, 8'h00);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 4) b = 8'h50;
        else if (r < 9) b = 8'($urandom);
        else b = pool[$urandom_range(0, pool.size() - 1)];
        cyc(1, b);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
